// File: rtl/audio_sample_fifo_pkg.sv
// audio_sample_fifo_pkg: shared types, width helpers and constants for the audio sample FIFO
package audio_sample_fifo_pkg;
  typedef enum logic {OVERFLOW_DROP = 1'b0, OVERFLOW_CLEAR = 1'b1} overflow_mode_t;
  localparam int STATS_WIDTH = 16;
  function automatic int ptr_width(input int size);
    return $clog2(size);
  endfunction
  function automatic int count_width(input int size);
    return $clog2(size + 1);
  endfunction
endpackage

// File: rtl/ring_index_add.sv
// ring_index_add: (base + offset) mod SIZE for offset <= SIZE via a single compare-and-subtract
module ring_index_add
  import audio_sample_fifo_pkg::*;
#(
  parameter int SIZE = 128
) (
  input  logic [ptr_width(SIZE)-1:0]   base,
  input  logic [count_width(SIZE)-1:0] offset,
  output logic [ptr_width(SIZE)-1:0]   sum
);
  localparam int PW = ptr_width(SIZE);
  localparam int CW = count_width(SIZE);
  localparam logic [CW:0] LIMIT = (CW+1)'(SIZE);
  logic [CW:0] raw;
  assign raw = {{(CW+1-PW){1'b0}}, base} + {1'b0, offset};
  assign sum = PW'(raw >= LIMIT ? raw - LIMIT : raw);
endmodule

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: single-clock sample FIFO exposing the PARALLEL_OUT oldest samples per packet
// AUDIO_SAMPLE_FIFO_STATS_EN adds saturating overflow/underflow event counters
module audio_sample_fifo
  import audio_sample_fifo_pkg::*;
#(
  parameter int BUFFER_SIZE   = 128,
  parameter int BIT_WIDTH     = 16,
  parameter int CHANNELS      = 2,
  parameter int PARALLEL_OUT  = 4,
  parameter int OVERFLOW_MODE = 0
) (
  input  logic                                                  clk_pixel,
  input  logic                                                  reset,
  input  logic                                                  sample_valid,
  input  logic [CHANNELS-1:0][BIT_WIDTH-1:0]                    audio_in,
  input  logic                                                  packet_enable,
  output logic [PARALLEL_OUT-1:0][CHANNELS-1:0][BIT_WIDTH-1:0]  audio_out,
  output logic [PARALLEL_OUT-1:0]                               audio_out_valid,
  output logic [$clog2(PARALLEL_OUT+1)-1:0]                     pop_count,
  output logic [count_width(BUFFER_SIZE)-1:0]                   remaining,
  output logic                                                  empty,
  output logic                                                  full,
  output logic                                                  overflow,
  output logic                                                  underflow
`ifdef AUDIO_SAMPLE_FIFO_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]                                overflow_count,
  output logic [STATS_WIDTH-1:0]                                underflow_count
`endif
);
  localparam int PW  = ptr_width(BUFFER_SIZE);
  localparam int CW  = count_width(BUFFER_SIZE);
  localparam int PCW = $clog2(PARALLEL_OUT + 1);
  logic [PW-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
  logic [PW-1:0] lane_addr [PARALLEL_OUT];
  logic [CW-1:0] count;
  logic [CW:0] count_next;
  logic [CHANNELS-1:0][BIT_WIDTH-1:0] mem [BUFFER_SIZE];
  logic pop, push, ovf, unf, clear;
  assign remaining  = count;
  assign empty      = count == '0;
  assign full       = count == CW'(BUFFER_SIZE);
  assign pop_count  = count >= CW'(PARALLEL_OUT) ? PCW'(PARALLEL_OUT) : PCW'(count);
  assign pop        = packet_enable && !empty;
  assign unf        = packet_enable && empty;
  assign ovf        = sample_valid && full && !pop;
  assign push       = sample_valid && !ovf;
  assign clear      = ovf && OVERFLOW_MODE == int'(OVERFLOW_CLEAR);
  // popped slots are released before the push is counted, so full + pop + push is accepted
  assign count_next = {1'b0, count} - (CW+1)'(pop ? pop_count : '0) + (CW+1)'(push);
  ring_index_add #(.SIZE(BUFFER_SIZE)) u_rd_adv (.base(rd_ptr), .offset(CW'(pop_count)), .sum(rd_next));
  ring_index_add #(.SIZE(BUFFER_SIZE)) u_wr_adv (.base(wr_ptr), .offset(CW'(1)), .sum(wr_next));
  for (genvar k = 0; k < PARALLEL_OUT; k++) begin : g_lane
    ring_index_add #(.SIZE(BUFFER_SIZE)) u_addr (.base(rd_ptr), .offset(CW'(k)), .sum(lane_addr[k]));
    assign audio_out_valid[k] = count > CW'(k);
    assign audio_out[k]       = audio_out_valid[k] ? mem[lane_addr[k]] : '0;
  end
  always_ff @(posedge clk_pixel) begin
    if (!reset && (push || clear)) mem[wr_ptr] <= audio_in;
  end
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf;
      underflow <= unf;
      if (clear) begin
        rd_ptr <= wr_ptr;
        wr_ptr <= wr_next;
        count  <= CW'(1);
      end else begin
        if (pop) rd_ptr <= rd_next;
        if (push) wr_ptr <= wr_next;
        count <= CW'(count_next);
      end
    end
  end
`ifdef AUDIO_SAMPLE_FIFO_STATS_EN
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      overflow_count  <= '0;
      underflow_count <= '0;
    end else begin
      if (ovf && overflow_count != '1) overflow_count <= overflow_count + 1'b1;
      if (unf && underflow_count != '1) underflow_count <= underflow_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: directed checks on three FIFO configurations driven by shared stimulus
module tb_audio_sample_fifo;
  logic clk_pixel = 1'b0;
  logic reset, sample_valid, packet_enable;
  logic [1:0][15:0] audio_in;
  logic [3:0][1:0][15:0] a_out, b_out, c_out;
  logic [3:0] a_vld, b_vld, c_vld;
  logic [2:0] a_pc, b_pc, c_pc;
  logic [2:0] a_rem;
  logic [7:0] b_rem, c_rem;
  logic a_emp, a_full, a_ovf, a_unf;
  logic b_emp, b_full, b_ovf, b_unf;
  logic c_emp, c_full, c_ovf, c_unf;
`ifdef AUDIO_SAMPLE_FIFO_STATS_EN
  logic [15:0] a_oc, a_uc, b_oc, b_uc, c_oc, c_uc;
`endif
  int checks = 0;
  int failures = 0;
  int idx = 1;
  int s;
  always #5 clk_pixel = ~clk_pixel;
  audio_sample_fifo #(.BUFFER_SIZE(6), .BIT_WIDTH(16), .CHANNELS(2), .PARALLEL_OUT(4), .OVERFLOW_MODE(0)) u_a (
    .clk_pixel(clk_pixel), .reset(reset), .sample_valid(sample_valid), .audio_in(audio_in),
    .packet_enable(packet_enable), .audio_out(a_out), .audio_out_valid(a_vld), .pop_count(a_pc),
    .remaining(a_rem), .empty(a_emp), .full(a_full), .overflow(a_ovf), .underflow(a_unf)
`ifdef AUDIO_SAMPLE_FIFO_STATS_EN
    , .overflow_count(a_oc), .underflow_count(a_uc)
`endif
  );
  audio_sample_fifo #(.BUFFER_SIZE(128), .BIT_WIDTH(16), .CHANNELS(2), .PARALLEL_OUT(4), .OVERFLOW_MODE(0)) u_b (
    .clk_pixel(clk_pixel), .reset(reset), .sample_valid(sample_valid), .audio_in(audio_in),
    .packet_enable(packet_enable), .audio_out(b_out), .audio_out_valid(b_vld), .pop_count(b_pc),
    .remaining(b_rem), .empty(b_emp), .full(b_full), .overflow(b_ovf), .underflow(b_unf)
`ifdef AUDIO_SAMPLE_FIFO_STATS_EN
    , .overflow_count(b_oc), .underflow_count(b_uc)
`endif
  );
  audio_sample_fifo #(.BUFFER_SIZE(128), .BIT_WIDTH(16), .CHANNELS(2), .PARALLEL_OUT(4), .OVERFLOW_MODE(1)) u_c (
    .clk_pixel(clk_pixel), .reset(reset), .sample_valid(sample_valid), .audio_in(audio_in),
    .packet_enable(packet_enable), .audio_out(c_out), .audio_out_valid(c_vld), .pop_count(c_pc),
    .remaining(c_rem), .empty(c_emp), .full(c_full), .overflow(c_ovf), .underflow(c_unf)
`ifdef AUDIO_SAMPLE_FIFO_STATS_EN
    , .overflow_count(c_oc), .underflow_count(c_uc)
`endif
  );
  function automatic logic [1:0][15:0] samp(input int i);
    return {16'(2 * i), 16'(2 * i - 1)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask
  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      audio_in = samp(idx);
      idx++;
      tick();
    end
    sample_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1; sample_valid = 1'b0; packet_enable = 1'b0; audio_in = '0;
    tick(); tick();
    chk("rst_rem", 64'(a_rem), 64'(0));
    chk("rst_empty", 64'(a_emp), 64'(1));
    chk("rst_full", 64'(a_full), 64'(0));
    chk("rst_valid", 64'(a_vld), 64'(0));
    chk("rst_out", 64'(a_out[0]), 64'(0));
    chk("rst_popcnt", 64'(a_pc), 64'(0));
    chk("rst_ovf", 64'(a_ovf), 64'(0));
    reset = 1'b0;
    push_n(3);
    chk("p3_rem", 64'(a_rem), 64'(3));
    chk("p3_valid", 64'(a_vld), 64'(4'b0111));
    chk("p3_popcnt", 64'(a_pc), 64'(3));
    chk("p3_lane3", 64'(a_out[3]), 64'(0));
    chk("p3_lane0", 64'(a_out[0]), 64'(samp(1)));
    chk("p3_lane2", 64'(a_out[2]), 64'(samp(3)));
    chk("p3_b_rem", 64'(b_rem), 64'(3));
    push_n(7);
    chk("p10_rem", 64'(a_rem), 64'(6));
    chk("p10_full", 64'(a_full), 64'(1));
    chk("p10_ovf", 64'(a_ovf), 64'(1));
    chk("p10_valid", 64'(a_vld), 64'(4'b1111));
    chk("p10_popcnt", 64'(a_pc), 64'(4));
    chk("p10_b_rem", 64'(b_rem), 64'(10));
    packet_enable = 1'b1; tick(); packet_enable = 1'b0;
    chk("pop4_rem", 64'(a_rem), 64'(2));
    chk("pop4_lane0", 64'(a_out[0]), 64'(samp(5)));
    chk("pop4_lane1", 64'(a_out[1]), 64'(samp(6)));
    chk("pop4_valid", 64'(a_vld), 64'(4'b0011));
    chk("pop4_ovf", 64'(a_ovf), 64'(0));
    chk("pop4_b_rem", 64'(b_rem), 64'(6));
    chk("pop4_b_lane0", 64'(b_out[0]), 64'(samp(5)));
    for (int r = 0; r < 3; r++) begin
      s = idx;
      push_n(4);
      chk("wrap_full", 64'(a_full), 64'(1));
      packet_enable = 1'b1; tick(); packet_enable = 1'b0;
      chk("wrap_rem", 64'(a_rem), 64'(2));
      chk("wrap_lane0", 64'(a_out[0]), 64'(samp(s + 2)));
      chk("wrap_lane1", 64'(a_out[1]), 64'(samp(s + 3)));
    end
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_b_rem", 64'(b_rem), 64'(0));
    idx = 1;
    push_n(128);
    chk("fill_b_full", 64'(b_full), 64'(1));
    chk("fill_b_rem", 64'(b_rem), 64'(128));
    chk("fill_b_lane0", 64'(b_out[0]), 64'(samp(1)));
    chk("fill_b_lane3", 64'(b_out[3]), 64'(samp(4)));
    chk("fill_c_full", 64'(c_full), 64'(1));
    for (int j = 0; j < 3; j++) begin
      sample_valid = 1'b1; audio_in = samp(idx); idx++;
      tick();
      chk("drop_ovf", 64'(b_ovf), 64'(1));
      chk("drop_rem", 64'(b_rem), 64'(128));
      chk("drop_lane0", 64'(b_out[0]), 64'(samp(1)));
      chk("clr_rem", 64'(c_rem), 64'(j + 1));
      chk("clr_lane0", 64'(c_out[0]), 64'(samp(129)));
      chk("clr_ovf", 64'(c_ovf), 64'(j == 0));
    end
    chk("drop_a_rem", 64'(a_rem), 64'(6));
    chk("drop_a_lane0", 64'(a_out[0]), 64'(samp(1)));
    chk("c_popcnt", 64'(c_pc), 64'(3));
    sample_valid = 1'b1; audio_in = samp(idx); idx++; packet_enable = 1'b1;
    tick();
    sample_valid = 1'b0; packet_enable = 1'b0;
    chk("pp_ovf", 64'(b_ovf), 64'(0));
    chk("pp_rem", 64'(b_rem), 64'(125));
    chk("pp_lane0", 64'(b_out[0]), 64'(samp(5)));
    chk("pp_c_rem", 64'(c_rem), 64'(1));
    chk("pp_c_lane0", 64'(c_out[0]), 64'(samp(132)));
    tick();
    chk("idle_ovf", 64'(b_ovf), 64'(0));
    reset = 1'b1; tick(); reset = 1'b0;
    packet_enable = 1'b1; tick(); packet_enable = 1'b0;
    chk("unf_pulse", 64'(b_unf), 64'(1));
    chk("unf_rem", 64'(b_rem), 64'(0));
    chk("unf_empty", 64'(b_emp), 64'(1));
    chk("unf_a_pulse", 64'(a_unf), 64'(1));
    tick();
    chk("unf_clear", 64'(b_unf), 64'(0));
    push_n(2);
    chk("pre_rst_rem", 64'(b_rem), 64'(2));
    reset = 1'b1; sample_valid = 1'b1; packet_enable = 1'b1;
    tick();
    reset = 1'b0; sample_valid = 1'b0; packet_enable = 1'b0;
    chk("rst_win_rem", 64'(b_rem), 64'(0));
    chk("rst_win_empty", 64'(b_emp), 64'(1));
    chk("rst_win_valid", 64'(b_vld), 64'(0));
    chk("rst_win_unf", 64'(b_unf), 64'(0));
`ifdef AUDIO_SAMPLE_FIFO_STATS_EN
    chk("st_oc_rst", 64'(a_oc), 64'(0));
    chk("st_uc_rst", 64'(a_uc), 64'(0));
    packet_enable = 1'b1; tick(); packet_enable = 1'b0;
    chk("st_uc_one", 64'(a_uc), 64'(1));
    idx = 1;
    push_n(6);
    sample_valid = 1'b1;
    repeat (5) tick();
    chk("st_oc_five", 64'(a_oc), 64'(5));
    repeat (69995) tick();
    sample_valid = 1'b0;
    chk("st_oc_sat", 64'(a_oc), 64'(16'hFFFF));
    tick();
    chk("st_oc_hold", 64'(a_oc), 64'(16'hFFFF));
    reset = 1'b1; tick(); reset = 1'b0;
    chk("st_oc_clr", 64'(a_oc), 64'(0));
    chk("st_uc_clr", 64'(a_uc), 64'(0));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
